// File: rtl/vga_pkg.sv
// Shared video-pipeline constants: 800x600 @ 60 Hz raster geometry and counter width.
// Geometry parameters default from here so every stage agrees on the same raster.
package vga_pkg;

    localparam int COUNT_W     = 11;
    localparam int FRAME_CNT_W = 16;

    localparam int HOR_PIXELS = 800;
    localparam int H_FP       = 40;
    localparam int H_SYNC     = 128;
    localparam int H_BP       = 88;

    localparam int VER_PIXELS = 600;
    localparam int V_FP       = 1;
    localparam int V_SYNC     = 4;
    localparam int V_BP       = 23;

    localparam int HOR_TOTAL   = HOR_PIXELS + H_FP + H_SYNC + H_BP;
    localparam int VER_TOTAL   = VER_PIXELS + V_FP + V_SYNC + V_BP;
    localparam int HSYNC_START = HOR_PIXELS + H_FP;
    localparam int VSYNC_START = VER_PIXELS + V_FP;

    // True when count lies in [lo, lo+len); used for the sync windows.
    function automatic logic in_window(input logic [COUNT_W-1:0] count,
                                       input logic [COUNT_W-1:0] lo,
                                       input logic [COUNT_W:0]   len);
        logic [COUNT_W:0] cnt_ext;
        logic [COUNT_W:0] hi_ext;
        cnt_ext = {1'b0, count};
        hi_ext  = {1'b0, lo} + len;
        return (count >= lo) && (cnt_ext < hi_ext);
    endfunction

endpackage

// File: rtl/vga_tim_if.sv
// Raster bus shared by every stage of the video pipeline.
// The timing generator drives it through 'out'; downstream stages read it through 'in'.
interface vga_tim;
    import vga_pkg::*;

    logic [COUNT_W-1:0] hcount;
    logic [COUNT_W-1:0] vcount;
    logic               hsync;
    logic               hblnk;
    logic               vsync;
    logic               vblnk;

    modport out (output hcount, vcount, hsync, hblnk, vsync, vblnk);
    modport in  (input  hcount, vcount, hsync, hblnk, vsync, vblnk);

endinterface

// File: rtl/vga_timing.sv
// Raster generator: registered h/v counters with coherent blank/sync flags,
// plus a frame-start strobe and a free-running completed-frame counter.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = HOR_PIXELS,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = VER_PIXELS,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    vga_tim.out                    tim,
    output logic                   frame_start,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > (2 ** COUNT_W)) begin : g_h_width_check
            $error("vga_timing: H_TOTAL exceeds the 11-bit counter range");
        end
        if (V_TOTAL > (2 ** COUNT_W)) begin : g_v_width_check
            $error("vga_timing: V_TOTAL exceeds the 11-bit counter range");
        end
    endgenerate

    localparam logic [COUNT_W-1:0] H_LAST      = COUNT_W'(H_TOTAL - 1);
    localparam logic [COUNT_W-1:0] V_LAST      = COUNT_W'(V_TOTAL - 1);
    localparam logic [COUNT_W-1:0] H_BLNK_FROM = COUNT_W'(H_VISIBLE);
    localparam logic [COUNT_W-1:0] V_BLNK_FROM = COUNT_W'(V_VISIBLE);
    localparam logic [COUNT_W-1:0] H_SYNC_FROM = COUNT_W'(H_VISIBLE + H_FP);
    localparam logic [COUNT_W-1:0] V_SYNC_FROM = COUNT_W'(V_VISIBLE + V_FP);
    localparam logic [COUNT_W:0]   H_SYNC_LEN  = (COUNT_W+1)'(H_SYNC);
    localparam logic [COUNT_W:0]   V_SYNC_LEN  = (COUNT_W+1)'(V_SYNC);

    logic [COUNT_W-1:0]     hcount_nxt;
    logic [COUNT_W-1:0]     vcount_nxt;
    logic                   hsync_nxt;
    logic                   hblnk_nxt;
    logic                   vsync_nxt;
    logic                   vblnk_nxt;
    logic                   frame_wrap;
    logic [FRAME_CNT_W-1:0] frame_cnt_nxt;

    // Flags are derived from the next counts so they land in the same register
    // stage as the counts they describe.
    always_comb begin
        hcount_nxt    = tim.hcount;
        vcount_nxt    = tim.vcount;
        frame_wrap    = 1'b0;

        if (ce) begin
            if (tim.hcount == H_LAST) begin
                hcount_nxt = '0;
                if (tim.vcount == V_LAST) begin
                    vcount_nxt = '0;
                    frame_wrap = 1'b1;
                end else begin
                    vcount_nxt = tim.vcount + 1'b1;
                end
            end else begin
                hcount_nxt = tim.hcount + 1'b1;
            end
        end

        hblnk_nxt     = (hcount_nxt >= H_BLNK_FROM);
        vblnk_nxt     = (vcount_nxt >= V_BLNK_FROM);
        hsync_nxt     = in_window(hcount_nxt, H_SYNC_FROM, H_SYNC_LEN);
        vsync_nxt     = in_window(vcount_nxt, V_SYNC_FROM, V_SYNC_LEN);
        frame_cnt_nxt = frame_cnt + FRAME_CNT_W'(frame_wrap);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tim.hcount  <= '0;
            tim.vcount  <= '0;
            tim.hsync   <= 1'b0;
            tim.hblnk   <= 1'b0;
            tim.vsync   <= 1'b0;
            tim.vblnk   <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            tim.hcount  <= hcount_nxt;
            tim.vcount  <= vcount_nxt;
            tim.hsync   <= hsync_nxt;
            tim.hblnk   <= hblnk_nxt;
            tim.vsync   <= vsync_nxt;
            tim.vblnk   <= vblnk_nxt;
            frame_start <= frame_wrap;
            frame_cnt   <= frame_cnt_nxt;
        end
    end

endmodule
